// File: rtl/pio_bank_pkg.sv
// Shared definitions for the PIO bank: register offsets, edge-capture modes and
// small helper functions used by the channel logic.
package pio_bank_pkg;

    // Register offsets within a channel (low two word-address bits)
    localparam logic [1:0] REG_OUT  = 2'd0;
    localparam logic [1:0] REG_IN   = 2'd1;
    localparam logic [1:0] REG_MASK = 2'd2;
    localparam logic [1:0] REG_EDGE = 2'd3;

    // Edge-capture modes
    localparam logic [1:0] EDGE_RISE = 2'd0;
    localparam logic [1:0] EDGE_FALL = 2'd1;
    localparam logic [1:0] EDGE_ANY  = 2'd2;
    localparam logic [1:0] EDGE_NONE = 2'd3;

    // Per-bit edge event from current and previous synchronised samples
    function automatic logic [31:0] edge_vec(input logic [31:0] cur,
                                             input logic [31:0] prev,
                                             input logic [1:0]  mode);
        logic [31:0] ev;
        case (mode)
            EDGE_RISE: ev = cur & ~prev;
            EDGE_FALL: ev = ~cur & prev;
            EDGE_ANY:  ev = cur ^ prev;
            EDGE_NONE: ev = 32'd0;
            default:   ev = 32'd0;
        endcase
        return ev;
    endfunction

    // Expand the four byte-lane enables into a 32-bit bit mask
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/pio_channel.sv
// One PIO channel: output register, two-flop input synchroniser, edge capture
// with write-1-to-clear, interrupt mask and the channel's interrupt term.
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   wr_en             write strobe already decoded for this channel
//   reg_sel           register offset for both read and write
//   wr_data, wr_be    write data and byte-lane enables
//   pio_in            asynchronous channel inputs
//   pio_out           output register
//   rd_data           selected register, zero-extended to 32 bits
//   irq_term          OR of (EDGE & MASK) for this channel
module pio_channel
    import pio_bank_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter logic [1:0]  EDGE_MODE = 2'd1,
    parameter logic [31:0] OUT_RESET = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [1:0]        reg_sel,
    input  logic [31:0]       wr_data,
    input  logic [3:0]        wr_be,
    input  logic [DATA_W-1:0] pio_in,
    output logic [DATA_W-1:0] pio_out,
    output logic [31:0]       rd_data,
    output logic              irq_term
);

    logic [DATA_W-1:0] out_r;
    logic [DATA_W-1:0] mask_r;
    logic [DATA_W-1:0] edge_r;
    logic [DATA_W-1:0] sync1_r;
    logic [DATA_W-1:0] sync2_r;
    logic [DATA_W-1:0] prev_r;

    logic [31:0]       be_mask_s;
    logic [31:0]       out_next_s;
    logic [31:0]       mask_next_s;
    logic [31:0]       event_full_s;
    logic [DATA_W-1:0] event_s;
    logic [DATA_W-1:0] clear_s;
    logic              out_we_s;
    logic              mask_we_s;
    logic              edge_w1c_s;

    assign be_mask_s    = be_to_mask(wr_be);
    // Byte-lane merge over the zero-extended register; bits above DATA_W drop off
    assign out_next_s   = (32'(out_r) & ~be_mask_s) | (wr_data & be_mask_s);
    assign mask_next_s  = (32'(mask_r) & ~be_mask_s) | (wr_data & be_mask_s);
    assign event_full_s = edge_vec(32'(sync2_r), 32'(prev_r), EDGE_MODE);
    assign event_s      = event_full_s[DATA_W-1:0];

    // Write decode for this channel's writable registers
    always_comb begin
        out_we_s   = 1'b0;
        mask_we_s  = 1'b0;
        edge_w1c_s = 1'b0;
        if (wr_en) begin
            case (reg_sel)
                REG_OUT:  out_we_s   = 1'b1;
                REG_MASK: mask_we_s  = 1'b1;
                REG_EDGE: edge_w1c_s = 1'b1;
                default:  out_we_s   = 1'b0;
            endcase
        end else begin
            out_we_s = 1'b0;
        end
    end

    // Bits a W1C write asks to clear (byte lanes honoured)
    assign clear_s = edge_w1c_s ? (wr_data[DATA_W-1:0] & be_mask_s[DATA_W-1:0])
                                : {DATA_W{1'b0}};

    // Output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_r <= OUT_RESET[DATA_W-1:0];
        end else if (out_we_s) begin
            out_r <= out_next_s[DATA_W-1:0];
        end
    end

    // Interrupt mask register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_r <= {DATA_W{1'b0}};
        end else if (mask_we_s) begin
            mask_r <= mask_next_s[DATA_W-1:0];
        end
    end

    // Input synchroniser and previous-sample register for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= {DATA_W{1'b0}};
            sync2_r <= {DATA_W{1'b0}};
            prev_r  <= {DATA_W{1'b0}};
        end else begin
            sync1_r <= pio_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Edge capture; OR-ing the event after the clear lets a same-cycle event win
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_r <= {DATA_W{1'b0}};
        end else begin
            edge_r <= (edge_r & ~clear_s) | event_s;
        end
    end

    // Read selection, zero-extended to the bus width
    always_comb begin
        case (reg_sel)
            REG_OUT:  rd_data = 32'(out_r);
            REG_IN:   rd_data = 32'(sync2_r);
            REG_MASK: rd_data = 32'(mask_r);
            REG_EDGE: rd_data = 32'(edge_r);
            default:  rd_data = 32'd0;
        endcase
    end

    assign pio_out  = out_r;
    assign irq_term = |(edge_r & mask_r);

endmodule

// File: rtl/pio_bank_avmm.sv
// Multi-channel parallel I/O bank on an Avalon-MM slave port with a single
// registered level interrupt.
// Ports:
//   clk, reset                 clock and asynchronous active-high reset
//   avs_address                word address {channel, reg[1:0]}
//   avs_read, avs_write        access strobes (no waitrequest)
//   avs_writedata, avs_byteenable  write data and byte lanes
//   avs_readdata, avs_readdatavalid  read response, one cycle after avs_read
//   pio_in                     asynchronous inputs, channel c at [c*DATA_W +: DATA_W]
//   pio_out                    registered outputs
//   irq                        registered OR of all masked edge bits
module pio_bank_avmm
    import pio_bank_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          DATA_W    = 32,
    parameter logic [1:0]  EDGE_MODE = 2'd1,
    parameter logic [31:0] OUT_RESET = 32'h0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [$clog2(NUM_CH)+1:0]  avs_address,
    input  logic                       avs_read,
    input  logic                       avs_write,
    input  logic [31:0]                avs_writedata,
    input  logic [3:0]                 avs_byteenable,
    output logic [31:0]                avs_readdata,
    output logic                       avs_readdatavalid,
    input  logic [NUM_CH*DATA_W-1:0]   pio_in,
    output logic [NUM_CH*DATA_W-1:0]   pio_out,
    output logic                       irq
);

    localparam int CH_BITS = $clog2(NUM_CH);
    localparam int ADDR_W  = CH_BITS + 2;

    logic [4:0]               ch_idx_s;
    logic [NUM_CH-1:0]        ch_sel_s;
    logic [NUM_CH-1:0][31:0]  ch_rd_s;
    logic [NUM_CH-1:0]        irq_term_s;
    logic [31:0]              rd_mux_s;
    logic [31:0]              rdata_r;
    logic                     rvalid_r;
    logic                     irq_r;

    // With a single channel there are no channel address bits
    generate
        if (CH_BITS > 0) begin : g_idx
            assign ch_idx_s = 5'(avs_address[ADDR_W-1:2]);
        end else begin : g_idx_one
            assign ch_idx_s = 5'd0;
        end
    endgenerate

    // Channel decode; indices >= NUM_CH select nothing, so they read 0 and ignore writes
    always_comb begin
        ch_sel_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_sel_s[c] = (ch_idx_s == 5'(c));
        end
    end

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            pio_channel #(
                .DATA_W    (DATA_W),
                .EDGE_MODE (EDGE_MODE),
                .OUT_RESET (OUT_RESET)
            ) u_ch (
                .clk      (clk),
                .reset    (reset),
                .wr_en    (avs_write & ch_sel_s[g]),
                .reg_sel  (avs_address[1:0]),
                .wr_data  (avs_writedata),
                .wr_be    (avs_byteenable),
                .pio_in   (pio_in[g*DATA_W +: DATA_W]),
                .pio_out  (pio_out[g*DATA_W +: DATA_W]),
                .rd_data  (ch_rd_s[g]),
                .irq_term (irq_term_s[g])
            );
        end
    endgenerate

    // Read data mux: one-hot OR of the selected channel's read value
    always_comb begin
        rd_mux_s = 32'd0;
        for (int c = 0; c < NUM_CH; c++) begin
            rd_mux_s = rd_mux_s | (ch_sel_s[c] ? ch_rd_s[c] : 32'd0);
        end
    end

    // Read response register; samples pre-write state if read and write collide
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_r  <= 32'd0;
            rvalid_r <= 1'b0;
        end else begin
            rdata_r  <= avs_read ? rd_mux_s : 32'd0;
            rvalid_r <= avs_read;
        end
    end

    // Interrupt register: OR of all channels' masked edge bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |irq_term_s;
        end
    end

    assign avs_readdata      = rdata_r;
    assign avs_readdatavalid = rvalid_r;
    assign irq               = irq_r;

endmodule

// File: tb/tb_pio_bank_avmm.sv
module tb_pio_bank_avmm;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  avs_address = 4'd0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'd0;
    logic [3:0]  avs_byteenable = 4'd0;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic [95:0] pio_in = 96'd0;
    logic [95:0] pio_out;
    logic        irq;

    logic [31:0] b_readdata;
    logic        b_readdatavalid;
    logic [31:0] b_pio_in = 32'd0;
    logic [31:0] b_pio_out;
    logic        b_irq;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    pio_bank_avmm #(.NUM_CH(3), .DATA_W(32), .EDGE_MODE(2'd1), .OUT_RESET(32'hA5)) dut (
        .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
        .pio_in(pio_in), .pio_out(pio_out), .irq(irq)
    );

    pio_bank_avmm #(.NUM_CH(4), .DATA_W(8), .EDGE_MODE(2'd1), .OUT_RESET(32'h0)) dut8 (
        .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_readdata(b_readdata), .avs_readdatavalid(b_readdatavalid),
        .pio_in(b_pio_in), .pio_out(b_pio_out), .irq(b_irq)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    // Read: expectation queued at issue, popped when the response cycle arrives
    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] e;
        string t;
        exp_q.push_back(exp); tag_q.push_back(tag);
        avs_address = a; avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        e = exp_q.pop_front(); t = tag_q.pop_front();
        chk({t, "_valid"}, 128'(avs_readdatavalid), 128'(1'b1));
        chk(t, 128'(avs_readdata), 128'(e));
    endtask

    initial begin
        pio_in[31:0] = 32'h0000_0009;
        ticks(3);
        chk("reset_pio_out", 128'(pio_out), 128'({32'hA5, 32'hA5, 32'hA5}));
        chk("reset_irq", 128'(irq), 128'(1'b0));
        chk("reset_rvalid", 128'(avs_readdatavalid), 128'(1'b0));
        reset = 1'b0;
        ticks(4);

        rd(4'h6, 32'h0, "ch1_mask_reset");

        // Byte-enable write to channel 2 OUT
        wr(4'h8, 32'h0, 4'hF);
        wr(4'h8, 32'h1234_5678, 4'b0101);
        chk("be_pio_out_ch2", 128'(pio_out[95:64]), 128'(32'h0034_0078));
        rd(4'h8, 32'h0034_0078, "be_readback");
        chk("ch0_untouched", 128'(pio_out[31:0]), 128'(32'hA5));

        rd(4'h1, 32'h9, "in_ch0");
        rd(4'h3, 32'h0, "edge_ch0_idle");

        // Falling edge on bit0 with mask bit0
        wr(4'h2, 32'h1, 4'hF);
        pio_in[0] = 1'b0;
        ticks(3);
        chk("irq_before_4clk", 128'(irq), 128'(1'b0));
        ticks(1);
        chk("irq_at_4clk", 128'(irq), 128'(1'b1));
        rd(4'h3, 32'h1, "edge_bit0");
        wr(4'h3, 32'h1, 4'hF);
        chk("irq_w1c_n1", 128'(irq), 128'(1'b1));
        ticks(1);
        chk("irq_w1c_n2", 128'(irq), 128'(1'b0));
        rd(4'h3, 32'h0, "edge_cleared");

        // Event on bit3 colliding with its W1C
        wr(4'h2, 32'h8, 4'hF);
        pio_in[3] = 1'b0;
        ticks(4);
        chk("irq_bit3", 128'(irq), 128'(1'b1));
        pio_in[3] = 1'b1;
        ticks(4);
        pio_in[3] = 1'b0;
        ticks(2);
        wr(4'h3, 32'h8, 4'hF);
        chk("collide_irq_n1", 128'(irq), 128'(1'b1));
        ticks(1);
        chk("collide_irq_n2", 128'(irq), 128'(1'b1));
        rd(4'h3, 32'h8, "collide_edge");

        // Mask off then on over a pending edge bit
        wr(4'h2, 32'h0, 4'hF);
        chk("unmask_irq_n1", 128'(irq), 128'(1'b1));
        ticks(1);
        chk("unmask_irq_n2", 128'(irq), 128'(1'b0));
        wr(4'h2, 32'h8, 4'hF);
        chk("mask_irq_n1", 128'(irq), 128'(1'b0));
        ticks(1);
        chk("mask_irq_n2", 128'(irq), 128'(1'b1));

        // Out-of-range channel 3
        wr(4'hC, 32'hFFFF_FFFF, 4'hF);
        chk("oor_pio_out", 128'(pio_out), 128'({32'h0034_0078, 32'hA5, 32'hA5}));
        rd(4'hC, 32'h0, "oor_read_out");
        rd(4'hE, 32'h0, "oor_read_mask");

        // Simultaneous read and write: write lands, read returns old value
        exp_q.push_back(32'hA5); tag_q.push_back("rw_collide");
        avs_address = 4'h0; avs_writedata = 32'h55; avs_byteenable = 4'hF;
        avs_read = 1'b1; avs_write = 1'b1;
        @(negedge clk);
        avs_read = 1'b0; avs_write = 1'b0;
        chk("rw_collide_valid", 128'(avs_readdatavalid), 128'(1'b1));
        chk(tag_q.pop_front(), 128'(avs_readdata), 128'(exp_q.pop_front()));
        chk("rw_collide_out", 128'(pio_out[31:0]), 128'(32'h55));

        // Reset in the cycle after a read
        avs_address = 4'h0; avs_read = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1; avs_read = 1'b0;
        #1;
        chk("midrd_rvalid", 128'(avs_readdatavalid), 128'(1'b0));
        chk("midrd_rdata", 128'(avs_readdata), 128'(32'h0));
        chk("midrd_out", 128'(pio_out[31:0]), 128'(32'hA5));
        chk("midrd_irq", 128'(irq), 128'(1'b0));
        ticks(2);
        reset = 1'b0;
        ticks(1);
        rd(4'h0, 32'hA5, "post_reset_read");
        rd(4'h7, 32'h0, "post_reset_edge_ch1");

        // Narrow channel instance (DATA_W=8)
        wr(4'h0, 32'h0000_FFFF, 4'hF);
        chk("w8_pio_out", 128'(b_pio_out), 128'(32'h0000_00FF));
        rd(4'h0, 32'h0000_FFFF, "w8_main_read");
        chk("w8_rvalid", 128'(b_readdatavalid), 128'(1'b1));
        chk("w8_readback", 128'(b_readdata), 128'(32'hFF));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
